pkt_ts_capture: RTL and testbench

Parametrised inline packet timestamper for the user data path. Forwards every packet unchanged, parses the Ethernet/IPv4 header, and matches the IPv4 destination address against a masked key. For every Nth matching packet it writes a free-running clock timestamp into a bank of NUM_SLOTS capture registers; the bank runs in one-shot or ring mode. It generalises the earlier fixed 8-register, 16-bit, exact-match estimator and sits between any two user data path stages.

---
 rtl/pkt_ts_capture.sv | 224 ++++++++++++++++++++++
 tb/tb_pkt_ts_capture.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_ts_capture.sv
// Inline IPv4 packet timestamper: forwards the stream unchanged through a small FIFO and
// records a free-running timestamp for every Nth packet whose masked destination IP matches.
`timescale 1ns/1ps
module pkt_ts_capture #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = 8,
  parameter int NUM_SLOTS       = 8,
  parameter int TS_WIDTH        = 32,
  parameter int FIFO_DEPTH_BITS = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [CTRL_WIDTH-1:0]           in_ctrl,
  input  logic                            in_wr,
  output logic                            in_rdy,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [CTRL_WIDTH-1:0]           out_ctrl,
  output logic                            out_wr,
  input  logic                            out_rdy,
  input  logic                            cfg_enable,
  input  logic                            cfg_ring,
  input  logic [31:0]                     cfg_key,
  input  logic [31:0]                     cfg_mask,
  input  logic [15:0]                     cfg_decimate,
  input  logic                            cfg_clear,
  output logic [NUM_SLOTS*TS_WIDTH-1:0]   ts_bank,
  output logic [$clog2(NUM_SLOTS)-1:0]    wr_ptr,
  output logic                            bank_full,
  output logic [31:0]                     match_count,
  output logic [31:0]                     pkt_count
);

  localparam int PTR_W = $clog2(NUM_SLOTS);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CNT_W = FIFO_DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NFULL_LVL = CNT_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_EOP_WAIT
  } state_t;

  // ---------------------------------------------------------------- input FIFO
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0]       fifo_wr_idx;
  logic [FIFO_DEPTH_BITS-1:0]       fifo_rd_idx;
  logic [CNT_W-1:0]                 fifo_count;
  logic                             fifo_empty;
  logic                             fifo_full;
  logic                             fifo_push;
  logic                             rd_en;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_LVL);
  assign fifo_push  = in_wr && !fifo_full;
  assign in_rdy     = (fifo_count < NFULL_LVL);
  assign out_wr     = !fifo_empty && out_rdy;
  assign rd_en      = out_wr;
  assign {out_ctrl, out_data} = fifo_mem[fifo_rd_idx];

  // NOTE: the storage array carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wr_idx] <= {in_ctrl, in_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr_idx <= '0;
      fifo_rd_idx <= '0;
      fifo_count  <= '0;
    end else begin
      if (fifo_push) fifo_wr_idx <= fifo_wr_idx + 1'b1;
      if (rd_en)     fifo_rd_idx <= fifo_rd_idx + 1'b1;
      case ({fifo_push, rd_en})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- parser FSM
  state_t            state, state_nxt;
  logic [2:0]        word_idx;
  logic              ethertype_ok;
  logic [15:0]       dip_hi;
  logic              hit;
  logic              en_latch;
  logic [TS_WIDTH-1:0] ts_latch;
  logic [TS_WIDTH-1:0] clk_cnt;

  logic ctrl_zero;
  logic first_data;
  logic eop;
  logic commit;
  logic chk_type;
  logic cap_dip_hi;
  logic eval_hit;

  assign ctrl_zero = (out_ctrl == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    first_data = 1'b0;
    eop        = 1'b0;
    commit     = 1'b0;
    chk_type   = 1'b0;
    cap_dip_hi = 1'b0;
    eval_hit   = 1'b0;
    if (out_wr) begin
      case (state)
        ST_IDLE: begin
          if (ctrl_zero) begin
            first_data = 1'b1;
            state_nxt  = ST_HDR;
          end else if (out_ctrl != {CTRL_WIDTH{1'b1}}) begin
            // All-ones ctrl marks a module header; any other non-zero ctrl here ends a header-only frame.
            eop = 1'b1;
          end
        end
        ST_HDR: begin
          if (!ctrl_zero) begin
            eop       = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            chk_type   = (word_idx == 3'd1);
            cap_dip_hi = (word_idx == 3'd3);
            if (word_idx == 3'd4) begin
              eval_hit  = 1'b1;
              state_nxt = ST_EOP_WAIT;
            end
          end
        end
        ST_EOP_WAIT: begin
          if (!ctrl_zero) begin
            eop       = 1'b1;
            commit    = hit;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_idx     <= '0;
      ethertype_ok <= 1'b0;
      dip_hi       <= '0;
      hit          <= 1'b0;
      en_latch     <= 1'b0;
      ts_latch     <= '0;
      clk_cnt      <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
      if (first_data) begin
        ts_latch <= clk_cnt;
        en_latch <= cfg_enable;
        word_idx <= 3'd1;
      end else if (out_wr && state == ST_HDR) begin
        word_idx <= word_idx + 3'd1;
      end
      if (chk_type)   ethertype_ok <= (out_data[31:16] == 16'h0800);
      if (cap_dip_hi) dip_hi <= out_data[15:0];
      if (eval_hit) begin
        hit <= en_latch && ethertype_ok &&
               ((({dip_hi, out_data[63:48]} ^ cfg_key) & cfg_mask) == 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------- capture bank
  logic [TS_WIDTH-1:0] slots [NUM_SLOTS];
  logic [15:0]         dec_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= '0;
      wr_ptr      <= '0;
      bank_full   <= 1'b0;
      match_count <= '0;
      pkt_count   <= '0;
      dec_cnt     <= '0;
    end else if (cfg_clear) begin
      // Clear takes priority over a commit landing on the same edge.
      for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= '0;
      wr_ptr      <= '0;
      bank_full   <= 1'b0;
      match_count <= '0;
      pkt_count   <= '0;
      dec_cnt     <= '0;
    end else begin
      if (eop) pkt_count <= pkt_count + 32'd1;
      if (commit) begin
        match_count <= match_count + 32'd1;
        if (!bank_full) begin
          if (dec_cnt == 16'd0) begin
            slots[wr_ptr] <= ts_latch;
            dec_cnt       <= cfg_decimate;
            wr_ptr        <= wr_ptr + PTR_W'(1);
            if (!cfg_ring && wr_ptr == LAST_SLOT) bank_full <= 1'b1;
          end else begin
            dec_cnt <= dec_cnt - 16'd1;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_bank
    assign ts_bank[k*TS_WIDTH +: TS_WIDTH] = slots[k];
  end

endmodule

// File: tb/tb_pkt_ts_capture.sv
// Randomised bench for pkt_ts_capture: a packet-level model predicts the forwarded stream,
// counters and capture bank every cycle; directed phases pin the model with literal values.
`timescale 1ns/1ps
module tb_pkt_ts_capture;

  localparam int NS    = 8;
  localparam int TSW   = 8;
  localparam int FDB   = 3;
  localparam int DEPTH = 1 << FDB;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [63:0]      in_data = '0;
  logic [7:0]       in_ctrl = '0;
  logic             in_wr = 1'b0;
  logic             in_rdy;
  logic [63:0]      out_data;
  logic [7:0]       out_ctrl;
  logic             out_wr;
  logic             out_rdy = 1'b1;
  logic             cfg_enable = 1'b1;
  logic             cfg_ring = 1'b0;
  logic [31:0]      cfg_key = '0;
  logic [31:0]      cfg_mask = '0;
  logic [15:0]      cfg_decimate = '0;
  logic             cfg_clear = 1'b0;
  logic [NS*TSW-1:0] ts_bank;
  logic [2:0]       wr_ptr;
  logic             bank_full;
  logic [31:0]      match_count;
  logic [31:0]      pkt_count;

  pkt_ts_capture #(
    .DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_SLOTS(NS), .TS_WIDTH(TSW), .FIFO_DEPTH_BITS(FDB)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .cfg_enable(cfg_enable), .cfg_ring(cfg_ring), .cfg_key(cfg_key), .cfg_mask(cfg_mask),
    .cfg_decimate(cfg_decimate), .cfg_clear(cfg_clear),
    .ts_bank(ts_bank), .wr_ptr(wr_ptr), .bank_full(bank_full),
    .match_count(match_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct packed { logic [7:0] c; logic [63:0] d; } word_t;

  word_t       fifo_q[$];
  word_t       pkt_q[$];
  bit          in_pkt;
  logic [7:0]  m_cnt;
  logic [7:0]  m_ts;
  bit          m_en;
  logic [31:0] m_match, m_pkt;
  logic [7:0]  m_slot[NS];
  int          m_wp, m_dec;
  bit          m_full;
  bit          saw_nfull = 0;

  function automatic void model_zero_bank();
    m_match = 0; m_pkt = 0; m_wp = 0; m_dec = 0; m_full = 0;
    for (int i = 0; i < NS; i++) m_slot[i] = 0;
  endfunction

  function automatic void model_reset();
    fifo_q.delete(); pkt_q.delete();
    in_pkt = 0; m_cnt = 0; m_ts = 0; m_en = 0;
    model_zero_bank();
  endfunction

  // A packet hits when it is long enough to carry the full header, is IPv4, and its masked DIP matches.
  function automatic bit pkt_hits();
    logic [31:0] dip;
    if (!m_en || pkt_q.size() < 6) return 0;
    for (int i = 1; i <= 4; i++) if (pkt_q[i].c != 0) return 0;
    if (pkt_q[1].d[31:16] != 16'h0800) return 0;
    dip = {pkt_q[3].d[15:0], pkt_q[4].d[63:48]};
    return ((dip ^ cfg_key) & cfg_mask) == 32'd0;
  endfunction

  function automatic void model_commit();
    m_match++;
    if (m_full) return;
    if (m_dec != 0) begin
      m_dec--;
      return;
    end
    m_slot[m_wp] = m_ts;
    m_dec = int'(cfg_decimate);
    if (m_wp == NS - 1) begin
      m_wp = 0;
      if (!cfg_ring) m_full = 1;
    end else begin
      m_wp++;
    end
  endfunction

  function automatic void model_word(input word_t w);
    bit eop = 0;
    bit hit = 0;
    if (!in_pkt) begin
      if (w.c == 0) begin
        in_pkt = 1;
        pkt_q.delete();
        pkt_q.push_back(w);
        m_ts = m_cnt;
        m_en = cfg_enable;
      end else if (w.c != 8'hFF) begin
        eop = 1;
      end
    end else begin
      pkt_q.push_back(w);
      if (w.c != 0) begin
        eop = 1;
        hit = pkt_hits();
        in_pkt = 0;
      end
    end
    if (eop) begin
      m_pkt++;
      if (hit) model_commit();
    end
  endfunction

  function automatic void model_advance();
    bit    xfer = (fifo_q.size() > 0) && out_rdy;
    bit    push = in_wr && (fifo_q.size() < DEPTH);
    word_t w;
    if (xfer) begin
      w = fifo_q.pop_front();
      model_word(w);
    end
    if (push) fifo_q.push_back({in_ctrl, in_data});
    if (cfg_clear) model_zero_bank();
    m_cnt++;
  endfunction

  task automatic model_compare();
    logic [NS*TSW-1:0] exp_bank;
    bit exp_wr = (fifo_q.size() > 0) && out_rdy;
    for (int i = 0; i < NS; i++) exp_bank[i*TSW +: TSW] = m_slot[i];
    check("out_wr", out_wr, exp_wr);
    if (exp_wr) begin
      check("out_data", out_data, fifo_q[0].d);
      check("out_ctrl", out_ctrl, fifo_q[0].c);
    end
    check("in_rdy", in_rdy, fifo_q.size() < DEPTH - 1);
    if (!in_rdy) saw_nfull = 1;
    check("match_count", match_count, m_match);
    check("pkt_count", pkt_count, m_pkt);
    check("wr_ptr", wr_ptr, m_wp[2:0]);
    check("bank_full", bank_full, m_full);
    check("ts_bank", ts_bank, exp_bank);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset) model_compare();
      #2;
      if (reset) model_reset();
      else       model_advance();
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  int rdy_mode = 0;
  bit arm_clear = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = ~out_rdy;
        default: out_rdy = ($urandom_range(0, 1) != 0);
      endcase
    end
  end

  // Fires cfg_clear on the very cycle an EOP word transfers.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (arm_clear && out_wr && out_ctrl != 8'h00 && out_ctrl != 8'hFF) begin
        cfg_clear = 1'b1;
        arm_clear = 0;
        @(posedge clk); #1;
        cfg_clear = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] c, input logic [63:0] d);
    int g = 0;
    while (!in_rdy) begin
      tick();
      g++;
      if (g > 2000) begin
        $display("FAIL in_rdy_timeout: got 0 expected 1");
        $fatal(1, "in_rdy stuck low");
      end
    end
    in_wr = 1'b1; in_ctrl = c; in_data = d;
    tick();
    in_wr = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] dip, input logic [15:0] et, input int nwords, input bit hdr);
    logic [63:0] d;
    logic [7:0]  c;
    if (hdr) push(8'hFF, {$urandom, $urandom});
    for (int i = 0; i < nwords; i++) begin
      d = {$urandom, $urandom};
      if (i == 1) d[31:16] = et;
      if (i == 3) d[15:0]  = dip[31:16];
      if (i == 4) d[63:48] = dip[15:0];
      c = (i == nwords - 1) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      push(c, d);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (fifo_q.size() != 0) begin
      tick();
      g++;
      if (g > 3000) begin
        $display("FAIL drain_timeout: got %0d words expected 0", fifo_q.size());
        $fatal(1, "drain stuck");
      end
    end
    repeat (3) tick();
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    tick();
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_match"}, match_count, 32'd0);
    check({tag, "_pkt"}, pkt_count, 32'd0);
    check({tag, "_wr_ptr"}, wr_ptr, 3'd0);
    check({tag, "_full"}, bank_full, 1'b0);
    check({tag, "_bank"}, ts_bank, 64'd0);
  endtask

  // ---------------------------------------------------------------- test sequence
  logic [7:0] ts_diff;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_wr", out_wr, 1'b0);
    check("rst_in_rdy", in_rdy, 1'b1);
    check_zeroed("rst");
    reset = 1'b0;
    tick();

    // Exact match, one-shot
    cfg_key = 32'h0A000001; cfg_mask = 32'hFFFFFFFF; cfg_decimate = 0; cfg_ring = 0;
    for (int i = 0; i < 3; i++) send_pkt(32'h0A000001, 16'h0800, 8, 1);
    send_pkt(32'h0A000002, 16'h0800, 8, 1);
    drain();
    check("exact_match", match_count, 32'd3);
    check("exact_pkt", pkt_count, 32'd4);
    check("exact_wr_ptr", wr_ptr, 3'd3);
    check("exact_slot3", ts_bank[31:24], 8'd0);
    ts_diff = ts_bank[15:8] - ts_bank[7:0];
    check("exact_ts_spacing", ts_diff, 8'd9);
    pulse_clear();
    check_zeroed("clr1");

    // Mask and decimation
    cfg_mask = 32'hFFFFFF00; cfg_decimate = 2;
    for (int i = 0; i < 9; i++) send_pkt({24'h0A0000, 8'($urandom)}, 16'h0800, 6, 0);
    drain();
    check("dec_match", match_count, 32'd9);
    check("dec_wr_ptr", wr_ptr, 3'd3);
    check("dec_unused_slots", ts_bank[63:24], 40'd0);

    // One-shot fill, then ring selected while full
    pulse_clear();
    cfg_mask = 32'hFFFFFFFF; cfg_decimate = 0; cfg_ring = 0;
    for (int i = 0; i < 10; i++) send_pkt(32'h0A000001, 16'h0800, 6, 0);
    drain();
    check("oneshot_full", bank_full, 1'b1);
    check("oneshot_wr_ptr", wr_ptr, 3'd0);
    check("oneshot_match", match_count, 32'd10);
    cfg_ring = 1;
    send_pkt(32'h0A000001, 16'h0800, 6, 0);
    drain();
    check("ring_while_full", bank_full, 1'b1);
    check("ring_while_full_match", match_count, 32'd11);

    // Ring mode wraps
    pulse_clear();
    for (int i = 0; i < 10; i++) send_pkt(32'h0A000001, 16'h0800, 7, 0);
    drain();
    check("ring_full", bank_full, 1'b0);
    check("ring_wr_ptr", wr_ptr, 3'd2);

    // Non-matching traffic
    pulse_clear();
    cfg_ring = 0;
    send_pkt(32'h0A000001, 16'h0806, 8, 1);
    send_pkt(32'h0A000001, 16'h0800, 3, 0);
    drain();
    cfg_enable = 0;
    send_pkt(32'h0A000001, 16'h0800, 8, 0);
    drain();
    cfg_enable = 1;
    push(8'hFF, 64'h1);
    push(8'h80, 64'h2);
    drain();
    check("nomatch_match", match_count, 32'd0);
    check("nomatch_pkt", pkt_count, 32'd4);

    // Backpressure with a continuous stream
    pulse_clear();
    cfg_ring = 1;
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) send_pkt(32'h0A000001, 16'h0800, $urandom_range(6, 10), 0);
    drain();
    check("bp_nearly_full_seen", saw_nfull, 1'b1);
    check("bp_match", match_count, 32'd12);

    // Clear coinciding with a commit
    rdy_mode = 0;
    arm_clear = 1;
    send_pkt(32'h0A000001, 16'h0800, 6, 0);
    drain();
    check("clr_on_commit_armed", arm_clear, 1'b0);
    check_zeroed("clr_commit");

    // Random traffic; the 8-bit timestamp wraps many times here
    rdy_mode = 2;
    cfg_key = $urandom; cfg_mask = 32'hFFFF0000; cfg_decimate = 16'($urandom_range(0, 3));
    for (int i = 0; i < 40; i++) begin
      cfg_enable = ($urandom_range(0, 3) != 0);
      cfg_ring = ($urandom_range(0, 1) != 0);
      send_pkt(($urandom_range(0, 2) != 0) ? {cfg_key[31:16], 16'($urandom)} : $urandom,
               ($urandom_range(0, 9) != 0) ? 16'h0800 : 16'h86DD,
               $urandom_range(1, 10), $urandom_range(0, 1) != 0);
    end
    drain();

    // Asynchronous reset mid-packet
    rdy_mode = 0; cfg_enable = 1; cfg_ring = 0; cfg_mask = 32'hFFFFFFFF;
    send_pkt(cfg_key, 16'h0800, 6, 0);
    drain();
    push(8'h00, 64'h11);
    push(8'h00, 64'h22);
    push(8'h00, 64'h33);
    #1 reset = 1'b1;
    #1;
    check("arst_out_wr", out_wr, 1'b0);
    check("arst_in_rdy", in_rdy, 1'b1);
    check_zeroed("arst");
    tick();
    reset = 1'b0;
    tick();
    send_pkt(cfg_key, 16'h0800, 6, 0);
    drain();
    check("post_rst_match", match_count, 32'd1);
    check("post_rst_pkt", pkt_count, 32'd1);
    check("post_rst_wr_ptr", wr_ptr, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
